// File: rtl/fft_mmio_pkg.sv
// Shared register map, CTRL bit positions and Q1.15 helpers for the butterfly coprocessor.
package fft_mmio_pkg;

  localparam int unsigned OFF_A     = 0;
  localparam int unsigned OFF_B     = 1;
  localparam int unsigned OFF_W     = 2;
  localparam int unsigned OFF_CTRL  = 3;
  localparam int unsigned OFF_Y0    = 4;
  localparam int unsigned OFF_Y1    = 5;
  localparam int unsigned OFF_COUNT = 6;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_SCALE    = 1;
  localparam int unsigned CTRL_CLR_OVF  = 2;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_OVF   = 2;
  localparam int unsigned STAT_SCALE = 3;

  localparam logic [15:0] Q15_MAX = 16'h7FFF;
  localparam logic [15:0] Q15_MIN = 16'h8000;
  localparam logic [15:0] RND     = 16'h4000;

  typedef struct packed {
    logic        clip;
    logic [15:0] val;
  } sat16_t;

  function automatic sat16_t sat16(input logic signed [32:0] v);
    sat16_t r;
    if (v > 33'sd32767) begin
      r.clip = 1'b1;
      r.val  = Q15_MAX;
    end else if (v < -33'sd32768) begin
      r.clip = 1'b1;
      r.val  = Q15_MIN;
    end else begin
      r.clip = 1'b0;
      r.val  = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_mmio_cmul_q15.sv
// Two-stage Q1.15 complex multiply P = B * W: raw products, then round/saturate.
module cmul_q15
  import fft_mmio_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] b_i,
  input  logic [31:0] w_i,
  output logic        valid_o,
  output logic [15:0] pr_o,
  output logic [15:0] pi_o,
  output logic        sat_o
);

  logic signed [31:0] rr_q, ii_q, ri_q, ir_q;
  logic               v1_q;
  logic signed [32:0] pr_full, pi_full, pr_rnd, pi_rnd;
  sat16_t             pr_sat, pi_sat;

  always_comb begin
    pr_full = $signed({rr_q[31], rr_q}) - $signed({ii_q[31], ii_q});
    pi_full = $signed({ri_q[31], ri_q}) + $signed({ir_q[31], ir_q});
    // Round half up before dropping the 15 fractional bits.
    pr_rnd  = (pr_full + $signed({17'b0, RND})) >>> 15;
    pi_rnd  = (pi_full + $signed({17'b0, RND})) >>> 15;
    pr_sat  = sat16(pr_rnd);
    pi_sat  = sat16(pi_rnd);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q    <= '0;
      ii_q    <= '0;
      ri_q    <= '0;
      ir_q    <= '0;
      v1_q    <= 1'b0;
      pr_o    <= '0;
      pi_o    <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      rr_q    <= $signed(b_i[31:16]) * $signed(w_i[31:16]);
      ii_q    <= $signed(b_i[15:0]) * $signed(w_i[15:0]);
      ri_q    <= $signed(b_i[31:16]) * $signed(w_i[15:0]);
      ir_q    <= $signed(b_i[15:0]) * $signed(w_i[31:16]);
      v1_q    <= valid_i;
      pr_o    <= pr_sat.val;
      pi_o    <= pi_sat.val;
      sat_o   <= pr_sat.clip | pi_sat.clip;
      valid_o <= v1_q;
    end
  end

endmodule

// File: rtl/fft_bfly_mmio.sv
// Memory-mapped radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W in Q1.15 complex.
module fft_bfly_mmio
  import fft_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done_irq
);

  typedef enum logic [1:0] {StIdle, StMul, StRnd, StAdd} state_e;

  state_e            state_q;
  logic [31:0]       a_q, b_q, w_q;
  logic [31:0]       a0_q, b0_q, w0_q;
  logic              scale_q, done_q, ovf_q, ovf_d;
  logic [31:0]       y0_q, y1_q, y0_d, y1_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rdata_d;

  logic              mul_valid, mul_sat, add_clip, ovf_set;
  logic [15:0]       pr, pi;
  logic signed [16:0] s0r, s0i, s1r, s1i;
  sat16_t            y0r, y0i, y1r, y1i;

  logic ctrl_wr, start_wr, clr_wr, busy;

  assign busy     = (state_q != StIdle);
  assign ctrl_wr  = sel && we && (addr == ADDR_W'(OFF_CTRL));
  assign start_wr = ctrl_wr && wdata[CTRL_START] && !busy;
  assign clr_wr   = ctrl_wr && wdata[CTRL_CLR_OVF];
  assign done_irq = done_q;

  cmul_q15 u_cmul (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (state_q == StMul),
    .b_i     (b0_q),
    .w_i     (w0_q),
    .valid_o (mul_valid),
    .pr_o    (pr),
    .pi_o    (pi),
    .sat_o   (mul_sat)
  );

  // scale=1 halves the 17-bit sum, which can never overflow 16 bits.
  function automatic sat16_t finish(input logic signed [16:0] s, input logic scl);
    sat16_t r;
    if (scl) begin
      r.clip = 1'b0;
      r.val  = s[16:1];
    end else begin
      r = sat16($signed({{16{s[16]}}, s}));
    end
    return r;
  endfunction

  always_comb begin
    s0r      = $signed({a0_q[31], a0_q[31:16]}) + $signed({pr[15], pr});
    s0i      = $signed({a0_q[15], a0_q[15:0]})  + $signed({pi[15], pi});
    s1r      = $signed({a0_q[31], a0_q[31:16]}) - $signed({pr[15], pr});
    s1i      = $signed({a0_q[15], a0_q[15:0]})  - $signed({pi[15], pi});
    y0r      = finish(s0r, scale_q);
    y0i      = finish(s0i, scale_q);
    y1r      = finish(s1r, scale_q);
    y1i      = finish(s1i, scale_q);
    y0_d     = {y0r.val, y0i.val};
    y1_d     = {y1r.val, y1i.val};
    add_clip = y0r.clip | y0i.clip | y1r.clip | y1i.clip;
    ovf_set  = (state_q == StAdd) && mul_valid && (mul_sat || add_clip);
    // A coincident overflow event beats clear_ovf.
    ovf_d    = (ovf_q & ~clr_wr) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      w_q <= '0;
    end else if (sel && we) begin
      if (addr == ADDR_W'(OFF_A)) a_q <= wdata[31:0];
      if (addr == ADDR_W'(OFF_B)) b_q <= wdata[31:0];
      if (addr == ADDR_W'(OFF_W)) w_q <= wdata[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a0_q    <= '0;
      b0_q    <= '0;
      w0_q    <= '0;
      scale_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      y0_q    <= '0;
      y1_q    <= '0;
      count_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      case (state_q)
        StIdle: begin
          if (start_wr) begin
            a0_q    <= a_q;
            b0_q    <= b_q;
            w0_q    <= w_q;
            scale_q <= wdata[CTRL_SCALE];
            done_q  <= 1'b0;
            state_q <= StMul;
          end
        end
        StMul: state_q <= StRnd;
        StRnd: state_q <= StAdd;
        StAdd: begin
          if (mul_valid) begin
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            done_q  <= 1'b1;
            count_q <= count_q + CNT_W'(1);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (addr)
      ADDR_W'(OFF_A):     rdata_d = DATA_W'(a_q);
      ADDR_W'(OFF_B):     rdata_d = DATA_W'(b_q);
      ADDR_W'(OFF_W):     rdata_d = DATA_W'(w_q);
      ADDR_W'(OFF_CTRL):  rdata_d = DATA_W'({scale_q, ovf_q, done_q, busy});
      ADDR_W'(OFF_Y0):    rdata_d = DATA_W'(y0_q);
      ADDR_W'(OFF_Y1):    rdata_d = DATA_W'(y1_q);
      ADDR_W'(OFF_COUNT): rdata_d = DATA_W'(count_q);
      default:            rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (sel && !we) begin
      rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_mmio.sv
// Self-checking bench for fft_bfly_mmio using a reference model and a result scoreboard.
module tb_fft_bfly_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] y0;
    logic [31:0] y1;
    bit          ov;
  } exp_t;

  exp_t sb_q[$];
  bit   ovf_m = 1'b0;
  int   cnt_m = 0;

  fft_bfly_mmio #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Callers sit on a negedge; each access occupies exactly one posedge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  function automatic longint clip16(input longint v, output bit c);
    c = 1'b0;
    if (v > 32767) begin c = 1'b1; return 32767; end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] w, input bit scale);
    exp_t   e;
    longint ar, ai, br, bi, wr, wi, pr, pi, s;
    logic [15:0] h [4];
    bit c;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    e.ov = 1'b0;
    pr = clip16((br * wr - bi * wi + 16384) >>> 15, c); e.ov |= c;
    pi = clip16((br * wi + bi * wr + 16384) >>> 15, c); e.ov |= c;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: s = ar + pr;
        1: s = ai + pi;
        2: s = ar - pr;
        default: s = ai - pi;
      endcase
      if (scale) s = s >>> 1;
      else begin s = clip16(s, c); e.ov |= c; end
      h[k] = s[15:0];
    end
    e.y0 = {h[0], h[1]};
    e.y1 = {h[2], h[3]};
    return e;
  endfunction

  task automatic poll_done(input string name);
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      bus_read(5'd3, d);
      if (d[1]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done_poll: done never seen, last CTRL=%h", name, d);
    end
  endtask

  task automatic check_results(input string name, input bit scale);
    logic [31:0] d;
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: empty queue", name);
      return;
    end
    e = sb_q.pop_front();
    bus_read(5'd4, d);
    checks++;
    if (d !== e.y0) begin errors++; $display("FAIL %s Y0: got %h want %h", name, d, e.y0); end
    bus_read(5'd5, d);
    checks++;
    if (d !== e.y1) begin errors++; $display("FAIL %s Y1: got %h want %h", name, d, e.y1); end
    bus_read(5'd3, d);
    checks++;
    if (d !== {28'b0, scale, ovf_m, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s CTRL: got %h want %h", name, d, {28'b0, scale, ovf_m, 2'b10});
    end
    bus_read(5'd6, d);
    checks++;
    if (d !== 32'(cnt_m)) begin errors++; $display("FAIL %s COUNT: got %h want %h", name, d, cnt_m); end
    checks++;
    if (done_irq !== 1'b1) begin errors++; $display("FAIL %s done_irq: got %b want 1", name, done_irq); end
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] w, input bit scale, input bit clr);
    exp_t e;
    bus_write(5'd0, a);
    bus_write(5'd1, b);
    bus_write(5'd2, w);
    e = model(a, b, w, scale);
    sb_q.push_back(e);
    ovf_m = (ovf_m & !clr) | e.ov;
    cnt_m++;
    bus_write(5'd3, {29'b0, clr, scale, 1'b1});
    poll_done(name);
    check_results(name, scale);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (rdata !== 32'h0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h done_irq=%b want 0/0", rdata, done_irq);
    end
    for (int i = 0; i < 7; i++) begin
      bus_read(5'(i), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", i, d); end
    end
  endtask

  task automatic test_butterflies();
    do_op("basic",     32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0);
    do_op("twiddle_j", 32'h4000_0000, 32'h2000_0000, 32'h0000_7FFF, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    do_op("sat_noscale", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b0);
    do_op("sat_scale",   32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 1'b1);
    do_op("prod_clip",   32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    // ovf stays sticky until cleared explicitly.
    bus_write(5'd3, 32'h0);
    bus_read(5'd3, d);
    checks++;
    if (d[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", d[2]); end
    bus_write(5'd3, 32'h4);
    ovf_m = 1'b0;
    bus_read(5'd3, d);
    checks++;
    if (d[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", d[2]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    exp_t e;
    bus_write(5'd0, 32'h1234_0100);
    bus_write(5'd1, 32'h2000_E000);
    bus_write(5'd2, 32'h5A82_A57E);
    e = model(32'h1234_0100, 32'h2000_E000, 32'h5A82_A57E, 1'b0);
    sb_q.push_back(e);
    ovf_m |= e.ov;
    cnt_m++;
    bus_write(5'd3, 32'h1);           // E0
    bus_write(5'd3, 32'h3);           // E1: start+scale while busy, ignored
    bus_write(5'd1, 32'h7FFF_7FFF);   // E2: operand rewrite mid-flight
    poll_done("busy_protect");
    check_results("busy_protect", 1'b0);
    bus_read(5'd1, d);
    checks++;
    if (d !== 32'h7FFF_7FFF) begin errors++; $display("FAIL busy_B_rewrite: got %h want 7fff7fff", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, held;
    bus_write(5'd9, 32'hDEAD_BEEF);
    bus_read(5'd9, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped9: got %h want 0", d); end
    bus_write(5'd4, 32'hCAFE_F00D);
    bus_read(5'd0, held);
    checks++;
    if (held !== 32'h1234_0100) begin errors++; $display("FAIL A_hold: got %h want 12340100", held); end
    // Deselected traffic must neither write nor disturb rdata.
    sel = 1'b0; we = 1'b1; addr = 5'd0; wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    we = 1'b0;
    checks++;
    if (rdata !== held) begin errors++; $display("FAIL sel0_rdata: got %h want %h", rdata, held); end
    bus_read(5'd0, d);
    checks++;
    if (d !== 32'h1234_0100) begin errors++; $display("FAIL sel0_nowrite: got %h want 12340100", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    bus_write(5'd0, 32'h4000_0000);
    bus_write(5'd1, 32'h2000_0000);
    bus_write(5'd2, 32'h7FFF_0000);
    bus_write(5'd3, 32'h1);           // E0
    @(negedge clk);                   // E1
    reset = 1'b1;
    @(negedge clk);                   // E2 under reset
    reset = 1'b0;
    ovf_m = 1'b0;
    cnt_m = 0;
    repeat (5) @(negedge clk);
    for (int i = 3; i < 7; i++) begin
      bus_read(5'(i), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL midop_reg%0d: got %h want 0", i, d); end
    end
    checks++;
    if (done_irq !== 1'b0) begin errors++; $display("FAIL midop_irq: got %b want 0", done_irq); end
    do_op("after_reset", 32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_butterflies();
    test_saturation();
    test_back_to_back();
    test_unmapped();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
